// File: rtl/calendar_pkg.sv
// Shared constants and BCD helpers for the clock-calendar.
// Field selects, BCD limits, month length and BCD increment.
package calendar_pkg;

    localparam logic [2:0] SEL_SEC   = 3'd0;
    localparam logic [2:0] SEL_MIN   = 3'd1;
    localparam logic [2:0] SEL_HOUR  = 3'd2;
    localparam logic [2:0] SEL_DAY   = 3'd3;
    localparam logic [2:0] SEL_MONTH = 3'd4;
    localparam logic [2:0] SEL_YEAR  = 3'd5;

    localparam logic [7:0] SEC_MAX   = 8'h59;
    localparam logic [7:0] MIN_MAX   = 8'h59;
    localparam logic [7:0] HOUR_MAX  = 8'h23;
    localparam logic [7:0] MONTH_MAX = 8'h12;
    localparam logic [7:0] YEAR_MAX  = 8'h99;

    function automatic logic bcd_ok(input logic [7:0] v);
        bcd_ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // 10 mod 4 = 2, so year mod 4 = (2*tens + units) mod 4
    function automatic logic [7:0] days_in_month(input logic [7:0] month,
                                                 input logic [7:0] year);
        logic [1:0] m4;
        m4 = {year[4], 1'b0} + year[1:0];
        case (month)
            8'h04, 8'h06, 8'h09, 8'h11: days_in_month = 8'h30;
            8'h02: days_in_month = (m4 == 2'd0) ? 8'h29 : 8'h28;
            default: days_in_month = 8'h31;
        endcase
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] >= 4'd9) begin
            if (v[7:4] >= 4'd9) bcd_inc = 8'h00;
            else bcd_inc = {v[7:4] + 4'd1, 4'h0};
        end else begin
            bcd_inc = {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

endpackage

// File: rtl/tick_sync_edge.sv
// Two-flop synchronizer with rising-edge detect.
// Emits a one-cycle pulse per rising edge of an asynchronous input.
module tick_sync_edge (
    input  logic CLK_50M,
    input  logic nCLR,
    input  logic async_i,
    output logic pulse_o
);

    logic [2:0] sync_q;

    always_ff @(posedge CLK_50M or negedge nCLR) begin
        if (!nCLR) sync_q <= 3'b000;
        else sync_q <= {sync_q[1:0], async_i};
    end

    assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/clock_calendar_core.sv
// BCD time/date register set advanced by a 1 Hz tick,
// with range-checked field loads and month-length clamping.
module clock_calendar_core
    import calendar_pkg::*;
#(
    parameter logic [7:0] RST_HOUR  = 8'h00,
    parameter logic [7:0] RST_DAY   = 8'h01,
    parameter logic [7:0] RST_MONTH = 8'h01,
    parameter logic [7:0] RST_YEAR  = 8'h00
) (
    input  logic       CLK_50M,
    input  logic       nCLR,
    input  logic       Tick_1Hz,
    input  logic       Load,
    input  logic [2:0] Load_Sel,
    input  logic [7:0] Load_Val,
    output logic [7:0] Sec,
    output logic [7:0] Min,
    output logic [7:0] Hour,
    output logic [7:0] Day,
    output logic [7:0] Month,
    output logic [7:0] Year,
    output logic       Carry_Day,
    output logic       Load_Err
);

    logic       tick;
    logic [7:0] sec_q, min_q, hour_q, day_q, month_q, year_q;
    logic [7:0] sec_d, min_d, hour_d, day_d, month_d, year_d;
    logic       carry_q, carry_d, err_q, err_d, pend_q, pend_d;
    logic       step, val_ok;
    logic [7:0] dim_cur, dim_mon, dim_yr;

    tick_sync_edge u_sync (
        .CLK_50M (CLK_50M),
        .nCLR    (nCLR),
        .async_i (Tick_1Hz),
        .pulse_o (tick)
    );

    assign step    = tick | pend_q;
    assign val_ok  = bcd_ok(Load_Val);
    assign dim_cur = days_in_month(month_q, year_q);
    assign dim_mon = days_in_month(Load_Val, year_q);
    assign dim_yr  = days_in_month(month_q, Load_Val);

    always_comb begin
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        day_d   = day_q;
        month_d = month_q;
        year_d  = year_q;
        carry_d = 1'b0;
        err_d   = 1'b0;
        pend_d  = pend_q;
        if (Load) begin
            // a tick arriving during a load waits for Load to drop
            pend_d = step;
            case (Load_Sel)
                SEL_SEC: begin
                    if (val_ok && Load_Val <= SEC_MAX) sec_d = Load_Val;
                    else err_d = 1'b1;
                end
                SEL_MIN: begin
                    if (val_ok && Load_Val <= MIN_MAX) min_d = Load_Val;
                    else err_d = 1'b1;
                end
                SEL_HOUR: begin
                    if (val_ok && Load_Val <= HOUR_MAX) hour_d = Load_Val;
                    else err_d = 1'b1;
                end
                SEL_DAY: begin
                    if (val_ok && Load_Val != 8'h00 && Load_Val <= dim_cur)
                        day_d = Load_Val;
                    else err_d = 1'b1;
                end
                SEL_MONTH: begin
                    if (val_ok && Load_Val != 8'h00 && Load_Val <= MONTH_MAX) begin
                        month_d = Load_Val;
                        if (day_q > dim_mon) day_d = dim_mon;
                    end else err_d = 1'b1;
                end
                SEL_YEAR: begin
                    if (val_ok && Load_Val <= YEAR_MAX) begin
                        year_d = Load_Val;
                        if (day_q > dim_yr) day_d = dim_yr;
                    end else err_d = 1'b1;
                end
                default: err_d = 1'b1;
            endcase
        end else if (step) begin
            pend_d = 1'b0;
            if (sec_q != SEC_MAX) sec_d = bcd_inc(sec_q);
            else begin
                sec_d = 8'h00;
                if (min_q != MIN_MAX) min_d = bcd_inc(min_q);
                else begin
                    min_d = 8'h00;
                    if (hour_q != HOUR_MAX) hour_d = bcd_inc(hour_q);
                    else begin
                        hour_d  = 8'h00;
                        carry_d = 1'b1;
                        if (day_q < dim_cur) day_d = bcd_inc(day_q);
                        else begin
                            day_d = 8'h01;
                            if (month_q != MONTH_MAX) month_d = bcd_inc(month_q);
                            else begin
                                month_d = 8'h01;
                                year_d  = bcd_inc(year_q);
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK_50M or negedge nCLR) begin
        if (!nCLR) begin
            sec_q   <= 8'h00;
            min_q   <= 8'h00;
            hour_q  <= RST_HOUR;
            day_q   <= RST_DAY;
            month_q <= RST_MONTH;
            year_q  <= RST_YEAR;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            day_q   <= day_d;
            month_q <= month_d;
            year_q  <= year_d;
            carry_q <= carry_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
        end
    end

    assign Sec       = sec_q;
    assign Min       = min_q;
    assign Hour      = hour_q;
    assign Day       = day_q;
    assign Month     = month_q;
    assign Year      = year_q;
    assign Carry_Day = carry_q;
    assign Load_Err  = err_q;

endmodule

// File: tb/tb_clock_calendar_core.sv
// Randomized and directed bench for clock_calendar_core.
// Reference model keeps time as plain integers.
module tb_clock_calendar_core;

    logic       CLK_50M = 1'b0;
    logic       nCLR, Tick_1Hz, Load;
    logic [2:0] Load_Sel;
    logic [7:0] Load_Val;
    logic [7:0] Sec, Min, Hour, Day, Month, Year;
    logic       Carry_Day, Load_Err;

    int n_tests = 0;
    int n_fail  = 0;
    int m_sec, m_min, m_hour, m_day, m_mon, m_yr;

    clock_calendar_core dut (
        .CLK_50M   (CLK_50M),
        .nCLR      (nCLR),
        .Tick_1Hz  (Tick_1Hz),
        .Load      (Load),
        .Load_Sel  (Load_Sel),
        .Load_Val  (Load_Val),
        .Sec       (Sec),
        .Min       (Min),
        .Hour      (Hour),
        .Day       (Day),
        .Month     (Month),
        .Year      (Year),
        .Carry_Day (Carry_Day),
        .Load_Err  (Load_Err)
    );

    always #10 CLK_50M = ~CLK_50M;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic int dim(input int mo, input int yr);
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        if (mo == 2) return (yr % 4 == 0) ? 29 : 28;
        return 31;
    endfunction

    task automatic m_reset;
        m_sec = 0; m_min = 0; m_hour = 0;
        m_day = 1; m_mon = 1; m_yr = 0;
    endtask

    task automatic m_tick(output bit carry);
        carry = 0;
        m_sec++;
        if (m_sec == 60) begin
            m_sec = 0; m_min++;
            if (m_min == 60) begin
                m_min = 0; m_hour++;
                if (m_hour == 24) begin
                    m_hour = 0; carry = 1; m_day++;
                    if (m_day > dim(m_mon, m_yr)) begin
                        m_day = 1; m_mon++;
                        if (m_mon > 12) begin
                            m_mon = 1;
                            m_yr = (m_yr + 1) % 100;
                        end
                    end
                end
            end
        end
    endtask

    task automatic m_load(input logic [2:0] sel, input logic [7:0] val,
                          output bit err);
        int v;
        err = 1;
        v = int'(val[7:4]) * 10 + int'(val[3:0]);
        if (val[7:4] <= 9 && val[3:0] <= 9) begin
            case (sel)
                3'd0: if (v <= 59) begin m_sec = v; err = 0; end
                3'd1: if (v <= 59) begin m_min = v; err = 0; end
                3'd2: if (v <= 23) begin m_hour = v; err = 0; end
                3'd3: if (v >= 1 && v <= dim(m_mon, m_yr)) begin
                    m_day = v; err = 0;
                end
                3'd4: if (v >= 1 && v <= 12) begin
                    m_mon = v; err = 0;
                    if (m_day > dim(m_mon, m_yr)) m_day = dim(m_mon, m_yr);
                end
                3'd5: begin
                    m_yr = v; err = 0;
                    if (m_day > dim(m_mon, m_yr)) m_day = dim(m_mon, m_yr);
                end
                default: ;
            endcase
        end
    endtask

    task automatic check_fields(input string tag);
        chk({tag, "_sec"}, Sec, bcd(m_sec));
        chk({tag, "_min"}, Min, bcd(m_min));
        chk({tag, "_hour"}, Hour, bcd(m_hour));
        chk({tag, "_day"}, Day, bcd(m_day));
        chk({tag, "_mon"}, Month, bcd(m_mon));
        chk({tag, "_yr"}, Year, bcd(m_yr));
    endtask

    task automatic do_load(input logic [2:0] sel, input logic [7:0] val);
        bit e;
        Load = 1; Load_Sel = sel; Load_Val = val;
        m_load(sel, val, e);
        @(negedge CLK_50M);
        Load = 0;
        chk("load_err", Load_Err, 32'(e));
        check_fields("load");
        @(negedge CLK_50M);
        chk("load_err_clr", Load_Err, 0);
    endtask

    // high 4 cycles, low 4 cycles; optional exact latency check
    task automatic tick(input bit exact);
        bit c;
        int ncar;
        logic [7:0] old_sec;
        old_sec = Sec;
        ncar = 0;
        m_tick(c);
        Tick_1Hz = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK_50M);
            if (Carry_Day) begin
                ncar++;
                chk("carry_hms", {Hour, Min, Sec}, 0);
            end
            if (exact && i == 1) chk("lat_old", Sec, old_sec);
            if (exact && i == 2) chk("lat_new", Sec, bcd(m_sec));
            if (i == 3) Tick_1Hz = 0;
        end
        chk("carry_cnt", ncar, 32'(c));
    endtask

    task automatic set_time(input logic [7:0] y, input logic [7:0] mo,
                            input logic [7:0] d);
        do_load(3'd5, y);
        do_load(3'd4, mo);
        do_load(3'd3, d);
        do_load(3'd2, 8'h23);
        do_load(3'd1, 8'h59);
        do_load(3'd0, 8'h59);
    endtask

    task automatic pend_test;
        logic [7:0] old_sec;
        old_sec = bcd(m_sec);
        Tick_1Hz = 1;
        @(negedge CLK_50M);
        @(negedge CLK_50M);
        Load = 1; Load_Sel = 3'd1; Load_Val = 8'h10;
        @(negedge CLK_50M);
        chk("pend_min", Min, 8'h10);
        chk("pend_sec_held", Sec, old_sec);
        chk("pend_err", Load_Err, 0);
        Load_Sel = 3'd0; Load_Val = 8'h05;
        @(negedge CLK_50M);
        Load = 0; Tick_1Hz = 0;
        chk("pend_sec_load", Sec, 8'h05);
        @(negedge CLK_50M);
        chk("pend_sec_tick", Sec, 8'h06);
        m_min = 10; m_sec = 6;
        repeat (4) @(negedge CLK_50M);
        check_fields("pend");
    endtask

    task automatic reset_test;
        Tick_1Hz = 1;
        @(negedge CLK_50M);
        @(negedge CLK_50M);
        Load = 1; Load_Sel = 3'd0; Load_Val = 8'h30;
        @(negedge CLK_50M);
        #2 nCLR = 0;
        Load = 0; Tick_1Hz = 0;
        m_reset();
        #1;
        check_fields("rst_async");
        chk("rst_carry", Carry_Day, 0);
        chk("rst_err", Load_Err, 0);
        @(negedge CLK_50M);
        nCLR = 1;
        repeat (6) @(negedge CLK_50M);
        check_fields("rst_nopend");
    endtask

    initial begin
        int r;
        logic [2:0] s;
        logic [7:0] v;
        nCLR = 0; Tick_1Hz = 0; Load = 0; Load_Sel = 0; Load_Val = 0;
        m_reset();
        repeat (3) @(negedge CLK_50M);
        check_fields("reset");
        chk("reset_carry", Carry_Day, 0);
        chk("reset_err", Load_Err, 0);
        nCLR = 1;
        @(negedge CLK_50M);

        for (int i = 0; i < 60; i++) tick(i == 0);
        chk("sixty_sec", Sec, 8'h00);
        chk("sixty_min", Min, 8'h01);

        set_time(8'h23, 8'h02, 8'h28);
        tick(0);
        check_fields("feb23");
        set_time(8'h24, 8'h02, 8'h28);
        tick(0);
        check_fields("feb24");
        set_time(8'h99, 8'h12, 8'h31);
        tick(0);
        check_fields("newyear");

        do_load(3'd0, 8'h60);
        do_load(3'd2, 8'h1A);
        do_load(3'd4, 8'h00);
        do_load(3'd6, 8'h12);
        do_load(3'd3, 8'h32);

        do_load(3'd4, 8'h01);
        do_load(3'd3, 8'h31);
        do_load(3'd4, 8'h04);
        chk("clamp30", Day, 8'h30);
        do_load(3'd5, 8'h24);
        do_load(3'd4, 8'h02);
        do_load(3'd3, 8'h29);
        do_load(3'd5, 8'h25);
        chk("clamp28", Day, 8'h28);

        pend_test();

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                s = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 1) == 1) v = bcd($urandom_range(0, 99));
                else v = 8'($urandom_range(0, 255));
                do_load(s, v);
            end else if (r == 5) begin
                if ($urandom_range(0, 1) == 1) do_load(3'd3, bcd(dim(m_mon, m_yr)));
                do_load(3'd2, 8'h23);
                do_load(3'd1, 8'h59);
                do_load(3'd0, 8'h59);
                tick(0);
                check_fields("rnd_roll");
            end else begin
                repeat ($urandom_range(1, 3)) tick(0);
                check_fields("rnd_tick");
            end
        end

        reset_test();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_calendar_core.md
# clock_calendar_core

Timekeeping core of the clock-calendar, directly downstream of the 50 MHz clock divider. It takes the divider's 1 Hz square wave and converts each rising edge into a one-cycle tick in the CLK_50M domain. Each tick advances a BCD seconds/minutes/hours/day/month/year register set with month-length and leap-year handling. A load port lets the panel logic set any field with range checking; the display and alarm stages read the outputs.

## Interface
- RST_HOUR, 8'h00: BCD hour after reset
- RST_DAY, 8'h01: BCD day after reset
- RST_MONTH, 8'h01: BCD month after reset
- RST_YEAR, 8'h00: BCD year after reset (00 = 2000)
- CLK_50M  in  1  system clock, 50 MHz
- nCLR  in  1  reset nCLR, asynchronous, active-low; clock CLK_50M
- Tick_1Hz  in  1  1 Hz square wave from the divider, asynchronous to CLK_50M; each rising edge = one second
- Load  in  1  level sampled every cycle; high = write Load_Val into the field selected by Load_Sel
- Load_Sel  in  3  0 sec, 1 min, 2 hour, 3 day, 4 month, 5 year; 6 and 7 reserved
- Load_Val  in  8  BCD value, {tens, units}
- Sec, Min, Hour, Day, Month, Year  out  8 each  registered BCD fields
- Carry_Day  out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 rollover
- Load_Err  out  1  one-cycle pulse when a load is rejected

## Operation
- Reset values: Sec=00, Min=00, Hour=RST_HOUR, Day=RST_DAY, Month=RST_MONTH, Year=RST_YEAR, Carry_Day=0, Load_Err=0, synchronizer flops=0, pending flag=0.
- Tick_1Hz passes through a 2-flop synchronizer, then a rising-edge detector; the detector output is the internal one-cycle tick.
- On tick: Sec+1. 59 -> 00 carries to Min; Min 59 -> 00 carries to Hour; Hour 23 -> 00 carries to Day and pulses Carry_Day.
- Day increments up to the days-in-month value, then goes to 01 and carries to Month.
- Days-in-month: 31 for months 01,03,05,07,08,10,12; 30 for 04,06,09,11; 02 has 29 if Year mod 4 = 0, else 28. Year range is 2000-2099, so no century rule applies.
- Month 12 -> 01 carries to Year; Year 99 -> 00.
- All arithmetic is BCD. A units nibble of 9 rolls to 0 and increments tens; no binary intermediate.
- Load validity: both nibbles ≤ 9, and the value is within range.
  - Ranges: sec/min 00-59, hour 00-23, month 01-12, year 00-99.
  - Day range is 01 to days-in-month of the current Month and Year.
- Invalid value or reserved Load_Sel: no field changes and Load_Err pulses.
- Month or Year load that leaves the current Day above the new days-in-month: Day clamps to that maximum in the same cycle (e.g. 31 -> 30, 29 -> 28).
- A loaded Sec does not clear the synchronizer; the next tick increments from the loaded value.
- Tick and Load in the same cycle: the load applies and the tick is held in a pending flag. The pending tick is applied on the first cycle with Load low; only one tick is stored. If a second tick arrives while one is pending, the second is dropped, which is not possible at 1 Hz unless Load is held for more than 1 s.

## Timing
- Tick_1Hz first sampled high at edge k: fields show the incremented value after edge k+2 (synchronizer 2 flops, edge detect, field register). This assumes Load was low.
- Carry_Day goes high in the same cycle the fields show 00:00:00 and lasts exactly one cycle.
- Load sampled high at edge k: the new field value and any Load_Err pulse are visible after edge k; Load_Err lasts one cycle.
- Load held high for n cycles rewrites the field n times; this is legal.
- nCLR low mid-carry or mid-load: all state returns to reset values immediately. A tick pending at reset is lost.
- Throughput: one tick per 50,000,000 cycles nominal. The core must still be correct with Tick_1Hz toggling every 4 cycles; benches use this fast tick.

## Structure
- Shared package calendar_pkg:
  - Load_Sel encodings SEL_SEC..SEL_YEAR
  - BCD limit constants (8'h59, 8'h23, 8'h12, 8'h99)
  - days_in_month(month, year) function returning BCD 28/29/30/31
  - bcd_inc function
- Sub-module tick_sync_edge: 2-flop synchronizer plus edge detector, async nCLR, one-cycle pulse out. It is reused for the other divider outputs feeding the display and alarm blocks.
- The field registers, the validity/clamp logic and the pending flag stay in clock_calendar_core.

## Test plan
- Reset, then 60 fast ticks -> Sec 59 -> 00, Min=01; no Carry_Day.
- Load 23:59:59, Day 28, Month 02, Year 23, then 1 tick -> 00:00:00, Day=01, Month=03, Carry_Day one cycle; same with Year 24 -> Day=29, Month=02.
- Load 23:59:59, Day 31, Month 12, Year 99, then 1 tick -> all fields 00:00:00 01/01/00.
- Invalid loads: Sec 8'h60, Hour 8'h1A, Month 8'h00, Load_Sel 6 -> fields unchanged, Load_Err pulses each time.
- Day 31, Month 01, then load Month 04 -> Day=30. Then Day 29, Month 02, Year 24, load Year 25 -> Day=28.
- Tick edge coincident with Load of Min=8'h10, Sec=8'h05 -> Min=10 immediately, Sec=06 one cycle after Load drops. nCLR pulsed mid-count -> reset values next cycle.
